// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default timing constants and clog2.
// Reused by the matching receiver.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level valid/ready handshake into the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = uart_pkg::DEFAULT_DATA_BITS
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and ticks on the last cycle.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered; tx falls on the handshake edge.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_if.slave      bus,
    output logic          tx,
    output logic          tx_busy
);
    localparam int BCW = clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shreg;
    logic [BCW-1:0]       bit_cnt;
    logic                 parity_bit;
    logic                 ready_q;
    logic                 tick;

    // Divider is held clear in IDLE so START always gets a full bit period;
    // all other state changes land on its wrap.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .tick  (tick)
    );

    assign bus.tx_ready = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            ready_q    <= 1'b1;
            tx_busy    <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.tx_valid) begin
                        shreg      <= bus.tx_data;
                        parity_bit <= (^bus.tx_data) ^ 1'(PARITY_ODD);
                        state      <= START;
                        tx         <= 1'b0;
                        ready_q    <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            tx_busy <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        tx <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    ready_q <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances at CLKS_PER_BIT=4 covering
// no parity, even parity, odd parity and two stop bits.
module tb_uart_tx;
    localparam int CPB = 4;
    localparam int NI  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] data_r  [NI];
    logic       valid_r [NI];
    logic       ready_w [NI];
    logic       tx_w    [NI];
    logic       busy_w  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_if #(.DATA_BITS(8)) bus ();
        assign bus.tx_data  = data_r[g];
        assign bus.tx_valid = valid_r[g];
        assign ready_w[g]   = bus.tx_ready;

        uart_tx #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (8),
            .PARITY_EN    ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD   ((g == 2) ? 1 : 0),
            .STOP_BITS    ((g == 3) ? 2 : 1)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (bus),
            .tx      (tx_w[g]),
            .tx_busy (busy_w[g])
        );
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int unsigned k, input string nm);
        int unsigned guard = 0;
        while (ready_w[k] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({nm, " ready-timeout"}, ready_w[k], 1'b1);
    endtask

    // Wire order is left to right in bits[nb-1:0]. Called at a negedge.
    task automatic send_frame(input int unsigned k, input logic [7:0] d,
                              input logic [11:0] bits, input int unsigned nb,
                              input string nm, input bit hold_valid);
        int unsigned b;
        wait_ready(k, nm);
        data_r[k]  = d;
        valid_r[k] = 1'b1;
        @(posedge clk);
        for (int unsigned j = 0; j < nb * CPB; j++) begin
            @(negedge clk);
            b = j / CPB;
            check($sformatf("%s tx[%0d]", nm, j), tx_w[k], bits[nb-1-b]);
            check($sformatf("%s busy[%0d]", nm, j), busy_w[k], 1'b1);
            check($sformatf("%s ready[%0d]", nm, j), ready_w[k], 1'b0);
            if (j == 0 && !hold_valid) valid_r[k] = 1'b0;
            if (j == 5) data_r[k] = ~d;
        end
        @(negedge clk);
        check({nm, " end tx"}, tx_w[k], 1'b1);
        check({nm, " end ready"}, ready_w[k], 1'b1);
        check({nm, " end busy"}, busy_w[k], 1'b0);
    endtask

    typedef struct {
        int unsigned inst;
        logic [7:0]  data;
        logic [11:0] bits;
        int unsigned nbits;
        string       name;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'hA5, 12'(10'b0_10100101_1),   10, "np_a5"};
        vecs[1] = '{0, 8'h01, 12'(10'b0_10000000_1),   10, "np_01"};
        vecs[2] = '{1, 8'hA5, 12'(11'b0_10100101_0_1), 11, "even_a5"};
        vecs[3] = '{2, 8'hA5, 12'(11'b0_10100101_1_1), 11, "odd_a5"};
        vecs[4] = '{1, 8'h07, 12'(11'b0_11100000_1_1), 11, "even_07"};
        vecs[5] = '{3, 8'h55, 12'(11'b0_10101010_1_1), 11, "stop2_55"};
        vecs[6] = '{2, 8'h00, 12'(11'b0_00000000_1_1), 11, "odd_00"};

        for (int i = 0; i < NI; i++) begin
            data_r[i]  = '0;
            valid_r[i] = 1'b0;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset tx%0d", i), tx_w[i], 1'b1);
            check($sformatf("reset ready%0d", i), ready_w[i], 1'b1);
            check($sformatf("reset busy%0d", i), busy_w[i], 1'b0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle tx c%0d", c), tx_w[0], 1'b1);
        end

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].inst, vecs[i].data, vecs[i].bits,
                       vecs[i].nbits, vecs[i].name, 1'b0);
        end

        // Back-to-back with valid held: one idle cycle between frames.
        send_frame(0, 8'h00, 12'(10'b0_00000000_1), 10, "b2b_00", 1'b1);
        send_frame(0, 8'hFF, 12'(10'b0_11111111_1), 10, "b2b_ff", 1'b0);

        // Reset during data bit 3 of 0x3C, then a clean frame.
        data_r[0]  = 8'h3C;
        valid_r[0] = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            if (j == 0) valid_r[0] = 1'b0;
        end
        check("midrst pre tx", tx_w[0], 1'b1);
        check("midrst pre busy", busy_w[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst tx", tx_w[0], 1'b1);
        check("midrst ready", ready_w[0], 1'b1);
        check("midrst busy", busy_w[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post rst idle tx", tx_w[0], 1'b1);
        send_frame(0, 8'h81, 12'(10'b0_10000001_1), 10, "after_rst_81", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
